// File: rtl/fe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fe_pkg
//  Description : Shared widths and bundle types for the instruction-fetch
//                front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fe_pkg;

    localparam int FETCH_W = 3;    // instructions per fetched line
    localparam int INST_W  = 13;   // bits per instruction
    localparam int PC_W    = 8;    // line-PC width

    typedef logic [INST_W-1:0] inst_t;

    // One fetched line together with the line PC it came from; lane 0 in LSBs
    typedef struct packed {
        inst_t [FETCH_W-1:0] inst;
        logic  [PC_W-1:0]    pc;
    } bundle_t;

endpackage
`default_nettype wire

// File: rtl/bundle_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bundle_fifo
//  Description : Circular FIFO of generic type T with synchronous flush and
//                an occupancy count one bit wider than the pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
module bundle_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq,
    input  T                         enq_data,
    input  logic                     deq,
    output T                         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = DEPTH[c_ptr_w:0];

    T                     r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_deq;

    // A pop on an empty queue is ignored rather than corrupting the pointers
    assign w_deq = deq && (r_count != '0);

    // Pointer and occupancy bookkeeping; flush empties the queue outright
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // The producer reserves a slot before requesting, so a full enqueue is a bug
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(enq && !flush && (r_count == c_full)));

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_unit
//  Description : Instruction-fetch stage. Walks line PCs, issues one I-cache
//                read at a time under stall back-pressure, and buffers fetched
//                bundles so fetch and decode stall independently. Supports a
//                flush with redirect and a stop after PC_LAST.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int FETCH_W = fe_pkg::FETCH_W,
    parameter int INST_W  = fe_pkg::INST_W,
    parameter int PC_W    = fe_pkg::PC_W,
    parameter int ADDR_W  = 30,
    parameter int LINE_W  = 64,
    parameter int QDEPTH  = 4,
    parameter int PC_LAST = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_in,
    input  logic [PC_W-1:0]               flush_pc_in,
    output logic                          ic_read_req_out,
    output logic [ADDR_W-1:0]             ic_addr_out,
    input  logic [LINE_W-1:0]             ic_data_in,
    input  logic                          cache_stall_in,
    output logic                          deq_valid_out,
    input  logic                          deq_ready_in,
    output logic [FETCH_W*INST_W-1:0]     deq_inst_out,
    output logic [PC_W-1:0]               deq_pc_out,
    output logic [$clog2(QDEPTH):0]       count_out
);

    import fe_pkg::*;

    localparam int               c_cnt_w   = $clog2(QDEPTH) + 1;
    localparam logic [c_cnt_w:0] c_qdepth  = (c_cnt_w + 1)'(QDEPTH);
    localparam logic [PC_W-1:0]  c_pc_last = PC_LAST[PC_W-1:0];

    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_req_pc;
    logic                r_fetch_en;
    logic                r_inflight;
    logic                r_drop;

    logic                w_credit;
    logic                w_req;
    logic                w_resp;
    logic                w_enq;
    logic                w_deq;
    logic [c_cnt_w-1:0]  w_count;
    bundle_t             w_enq_bundle;
    bundle_t             w_head;

    // Reserve a queue slot for the in-flight line so an enqueue never overflows
    assign w_credit = ({1'b0, w_count} + {{c_cnt_w{1'b0}}, r_inflight}) < c_qdepth;
    assign w_req    = r_fetch_en && !cache_stall_in && !flush_in && w_credit;

    // A stall holds both request and response, so a live response is inflight & !stall
    assign w_resp   = r_inflight && !cache_stall_in;
    assign w_enq    = w_resp && !r_drop && !flush_in;
    assign w_deq    = deq_valid_out && deq_ready_in && !flush_in;

    assign w_enq_bundle = {ic_data_in[FETCH_W*INST_W-1:0], r_req_pc};

    // The reset state has fetch enabled, so mask the request while reset is held
    assign ic_read_req_out = w_req && rst;

    // Line PC, end-of-program stop, outstanding-request and drop tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= '0;
            r_req_pc   <= '0;
            r_fetch_en <= 1'b1;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else if (flush_in) begin
            r_pc       <= flush_pc_in;
            r_fetch_en <= 1'b1;
            if (r_inflight && !w_resp) begin
                // Pre-flush line still owed by the cache: swallow it when it lands
                r_drop <= 1'b1;
            end else begin
                r_inflight <= 1'b0;
                r_drop     <= 1'b0;
            end
        end else begin
            if (w_resp) begin
                r_inflight <= 1'b0;
                r_drop     <= 1'b0;
            end
            if (w_req) begin
                r_req_pc   <= r_pc;
                r_inflight <= 1'b1;
                if (r_pc == c_pc_last) begin
                    r_fetch_en <= 1'b0;
                end
                // Saturate instead of wrapping back to line 0
                if (r_pc != {PC_W{1'b1}}) begin
                    r_pc <= r_pc + 1'b1;
                end
            end
        end
    end

    bundle_fifo #(
        .T     (bundle_t),
        .DEPTH (QDEPTH)
    ) u_bundle_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_in),
        .enq      (w_enq),
        .enq_data (w_enq_bundle),
        .deq      (w_deq),
        .head     (w_head),
        .count    (w_count)
    );

    assign deq_valid_out = (w_count != '0);
    assign deq_inst_out  = deq_valid_out ? w_head.inst : '0;
    assign deq_pc_out    = deq_valid_out ? w_head.pc   : '0;
    assign count_out     = w_count;

    if (ADDR_W > PC_W) begin : g_addr_ext
        assign ic_addr_out = {{(ADDR_W-PC_W){1'b0}}, r_pc};
    end else begin : g_addr_trunc
        assign ic_addr_out = r_pc[ADDR_W-1:0];
    end

    if (LINE_W > FETCH_W*INST_W) begin : g_unused_line
        // Bits above the last lane carry nothing for this stage
        logic w_unused_line_bits;
        assign w_unused_line_bits = ^ic_data_in[LINE_W-1:FETCH_W*INST_W];
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue_unit
//  Description : Self-checking bench for fetch_queue_unit: a constant vector
//                table for the start-up stream, hand-built corner sequences,
//                and random traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int PC_LAST = 5;
    localparam int QD      = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush_in = 1'b0;
    logic [7:0]   flush_pc_in = '0;
    logic         ic_read_req_out;
    logic [29:0]  ic_addr_out;
    logic [63:0]  ic_data_in = '0;
    logic         cache_stall_in = 1'b0;
    logic         deq_valid_out;
    logic         deq_ready_in = 1'b0;
    logic [38:0]  deq_inst_out;
    logic [7:0]   deq_pc_out;
    logic [2:0]   count_out;

    fetch_queue_unit #(
        .FETCH_W (3), .INST_W (13), .PC_W (8), .ADDR_W (30),
        .LINE_W  (64), .QDEPTH (QD), .PC_LAST (PC_LAST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_in        (flush_in),
        .flush_pc_in     (flush_pc_in),
        .ic_read_req_out (ic_read_req_out),
        .ic_addr_out     (ic_addr_out),
        .ic_data_in      (ic_data_in),
        .cache_stall_in  (cache_stall_in),
        .deq_valid_out   (deq_valid_out),
        .deq_ready_in    (deq_ready_in),
        .deq_inst_out    (deq_inst_out),
        .deq_pc_out      (deq_pc_out),
        .count_out       (count_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit [7:0] m_q[$];
    bit [7:0] m_pc, m_req_pc;
    bit       m_en, m_infl, m_drop, e_req;
    // Applied stimulus and cache model
    bit       s_stall, s_ready, s_flush;
    bit [7:0] s_fpc, cache_pc, samp_addr;
    bit       samp_req;

    typedef struct {
        bit       e_req;
        bit [7:0] e_addr;
        bit       e_valid;
        bit [2:0] e_count;
        bit [7:0] e_pc;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [63:0] line_of(input logic [7:0] p);
        logic [7:0] p3, p17;
        p3  = p * 8'd3;
        p17 = p + 8'd17;
        return {p ^ 8'hA5, 8'h5A, p, ~p, p3, 8'hC3, p17, p ^ 8'h96};
    endfunction

    function automatic logic [63:0] lanes_of(input logic [7:0] p);
        logic [63:0] l;
        l = line_of(p);
        return {25'd0, l[38:0]};
    endfunction

    function automatic vec_t mk(input bit rq, input bit [7:0] a, input bit v,
                                input bit [2:0] c, input bit [7:0] p);
        vec_t r;
        r.e_req = rq; r.e_addr = a; r.e_valid = v; r.e_count = c; r.e_pc = p;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc = 0; m_req_pc = 0; m_en = 1; m_infl = 0; m_drop = 0;
    endtask

    // Apply one cycle of stimulus just after the falling edge
    task automatic drive(input bit st, input bit rd, input bit fl, input bit [7:0] fp);
        @(negedge clk);
        rst = 1'b1;
        s_stall = st; s_ready = rd; s_flush = fl; s_fpc = fp;
        cache_stall_in = st; deq_ready_in = rd; flush_in = fl; flush_pc_in = fp;
        ic_data_in = st ? {$urandom(), $urandom()} : line_of(cache_pc);
        #1;
    endtask

    // Compare every observable output against the model
    task automatic check_model();
        e_req = m_en && !s_stall && !s_flush && ((m_q.size() + int'(m_infl)) < QD);
        chk("req", ic_read_req_out, e_req);
        if (e_req) chk("addr", ic_addr_out, m_pc);
        chk("valid", deq_valid_out, m_q.size() != 0);
        chk("count", count_out, m_q.size());
        if (m_q.size() != 0) begin
            chk("deq_pc", deq_pc_out, m_q[0]);
            chk("deq_inst", deq_inst_out, lanes_of(m_q[0]));
        end
        samp_req  = ic_read_req_out;
        samp_addr = ic_addr_out[7:0];
    endtask

    // Clock edge: cache captures the request, model applies the fetch rules
    task automatic advance();
        bit resp;
        @(posedge clk);
        if (samp_req) cache_pc = samp_addr;
        resp = m_infl && !s_stall;
        if (s_flush) begin
            m_q.delete();
            m_pc = s_fpc;
            m_en = 1;
            if (m_infl && !resp) m_drop = 1;
            else begin m_infl = 0; m_drop = 0; end
        end else begin
            if (m_q.size() != 0 && s_ready) m_q.delete(0);
            if (resp) begin
                if (!m_drop) m_q.push_back(m_req_pc);
                m_infl = 0; m_drop = 0;
            end
            if (e_req) begin
                m_req_pc = m_pc;
                m_infl   = 1;
                if (m_pc == PC_LAST) m_en = 0;
                if (m_pc != 8'hFF) m_pc++;
            end
        end
    endtask

    task automatic cyc(input bit st, input bit rd, input bit fl, input bit [7:0] fp);
        drive(st, rd, fl, fp);
        check_model();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        // Start-up stream from reset, no stall, decode always ready
        tbl[0] = mk(1, 8'h00, 0, 3'd0, 8'h00);
        tbl[1] = mk(1, 8'h01, 0, 3'd0, 8'h00);
        tbl[2] = mk(1, 8'h02, 1, 3'd1, 8'h00);
        tbl[3] = mk(1, 8'h03, 1, 3'd1, 8'h01);
        tbl[4] = mk(1, 8'h04, 1, 3'd1, 8'h02);
        tbl[5] = mk(1, 8'h05, 1, 3'd1, 8'h03);
        tbl[6] = mk(0, 8'h00, 1, 3'd1, 8'h04);
        tbl[7] = mk(0, 8'h00, 1, 3'd1, 8'h05);
        tbl[8] = mk(0, 8'h00, 0, 3'd0, 8'h00);
        tbl[9] = mk(0, 8'h00, 0, 3'd0, 8'h00);

        model_reset();
        cache_pc = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", ic_read_req_out, 0);
        chk("rst_valid", deq_valid_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_addr", ic_addr_out, 0);
        chk("rst_deq_pc", deq_pc_out, 0);
        chk("rst_deq_inst", deq_inst_out, 0);

        // Table: one request per cycle, 2-cycle latency, stop after PC_LAST, drain
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0);
            check_model();
            chk($sformatf("t1_req[%0d]", i), ic_read_req_out, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("t1_addr[%0d]", i), ic_addr_out, tbl[i].e_addr);
            chk($sformatf("t1_valid[%0d]", i), deq_valid_out, tbl[i].e_valid);
            chk($sformatf("t1_count[%0d]", i), count_out, tbl[i].e_count);
            if (tbl[i].e_valid) chk($sformatf("t1_pc[%0d]", i), deq_pc_out, tbl[i].e_pc);
            advance();
        end

        // Decode frozen: exactly QDEPTH requests accepted after flush-to-0 resumes fetch
        cyc(0, 0, 1, 8'h00);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0);
            check_model();
            if (i == 0) chk("t5_resume_req", ic_read_req_out, 1);
            acc += int'(ic_read_req_out);
            advance();
        end
        chk("t2_accepted", acc, QD);
        drive(0, 0, 0, 0);
        check_model();
        chk("t2_count_full", count_out, 3'd4);
        chk("t2_req_held", ic_read_req_out, 0);
        advance();
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);

        // Stall for 3 cycles while a response is owed
        cyc(0, 1, 1, 8'h10);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0);
            check_model();
            chk("t3_req_stall", ic_read_req_out, 0);
            chk("t3_addr_frozen", ic_addr_out, 8'h11);
            chk("t3_count_stall", count_out, 0);
            advance();
        end
        cyc(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        check_model();
        chk("t3_count", count_out, 1);
        chk("t3_pc", deq_pc_out, 8'h10);
        chk("t3_inst", deq_inst_out, lanes_of(8'h10));
        advance();
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);

        // Flush with three queued bundles and one stalled line in flight
        cyc(0, 0, 1, 8'h20);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        drive(1, 0, 1, 8'h40);
        check_model();
        chk("t4_count_pre", count_out, 3);
        advance();
        drive(1, 1, 0, 0);
        check_model();
        chk("t4_flushed", count_out, 0);
        advance();
        drive(0, 1, 0, 0);
        check_model();
        chk("t4_req", ic_read_req_out, 1);
        chk("t4_addr", ic_addr_out, 8'h40);
        advance();
        drive(0, 1, 0, 0);
        check_model();
        chk("t4_no_stale", count_out, 0);
        advance();
        drive(0, 1, 0, 0);
        check_model();
        chk("t4_valid", deq_valid_out, 1);
        chk("t4_first_pc", deq_pc_out, 8'h40);
        advance();
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);

        // Asynchronous reset while stalled with a line in flight
        cyc(0, 1, 1, 8'h30);
        cyc(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        check_model();
        #2 rst = 1'b0;
        #1;
        chk("t6_req", ic_read_req_out, 0);
        chk("t6_valid", deq_valid_out, 0);
        chk("t6_count", count_out, 0);
        chk("t6_addr", ic_addr_out, 0);
        chk("t6_deq_pc", deq_pc_out, 0);
        chk("t6_deq_inst", deq_inst_out, 0);
        model_reset();
        @(posedge clk);
        drive(0, 1, 0, 0);
        check_model();
        chk("t6_first_req", ic_read_req_out, 1);
        chk("t6_first_addr", ic_addr_out, 0);
        advance();
        drive(0, 1, 0, 0);
        check_model();
        chk("t6_no_ghost", count_out, 0);
        advance();

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom() % 4) == 0, ($urandom() % 3) != 0,
                ($urandom() % 25) == 0, 8'($urandom_range(0, 8'h70)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
